// File: rtl/gelato_types.sv
`default_nettype none
// ============================================================================
//  Module      : gelato_types (package)
//  Description : Shared types and constants for the Gelato issue stage.
//                WARP_NUM   - number of warps arbitrated by the scheduler
//                warp_num_t - warp index type
//                inst_t     - decoded instruction word carried to execute
//  Revision    : 1.0 - initial release
// ============================================================================
package gelato_types;

    localparam int WARP_NUM = 32;
    localparam int WARP_W   = $clog2(WARP_NUM);
    localparam int INST_W   = 32;

    typedef logic [WARP_W-1:0] warp_num_t;
    typedef logic [INST_W-1:0] inst_t;

    // One-hot vector with only bit w set.
    function automatic logic [WARP_NUM-1:0] warp_onehot(input warp_num_t w);
        return WARP_NUM'(1) << w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gelato_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : gelato_rr_picker
//  Description : Round-robin search over a request mask. The search visits
//                last+1, last+2, ... modulo N, so the index 'last' itself is
//                examined last.
//  Ports       : mask  - request bits, one per candidate
//                last  - index granted most recently
//                found - at least one mask bit is set
//                index - first set bit in round-robin order after 'last'
//  Revision    : 1.0 - initial release
// ============================================================================
module gelato_rr_picker #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (!found && mask[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gelato_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gelato_issue_scheduler
//  Description : Round-robin warp issue scheduler with a single issue slot.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                rdy                 - global enable, freezes everything when 0
//                ibuf_valid/ibuf_inst- per-warp head instruction
//                sb_ready            - per-warp scoreboard clear
//                ibuf_pop            - one-hot pop pulse after a slot load
//                issue_valid/ready   - issue slot handshake to execute
//                issue_warp_num/inst - issue slot contents
//                barrier_set/warp_num/release - barrier wait bookkeeping
//  Revision    : 1.0 - initial release
// ============================================================================
module gelato_issue_scheduler
    import gelato_types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic [WARP_NUM-1:0] ibuf_valid,
    input  inst_t               ibuf_inst [WARP_NUM],
    input  logic [WARP_NUM-1:0] sb_ready,
    output logic [WARP_NUM-1:0] ibuf_pop,
    output logic                issue_valid,
    input  logic                issue_ready,
    output warp_num_t           issue_warp_num,
    output inst_t               issue_inst,
    input  logic                barrier_set,
    input  warp_num_t           barrier_warp_num,
    input  logic                barrier_release
);

    typedef enum logic [0:0] {
        SELECT = 1'b0,
        HOLD   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    warp_num_t           last_warp_q, last_warp_d;
    warp_num_t           issue_warp_q, issue_warp_d;
    inst_t               issue_inst_q, issue_inst_d;
    logic                issue_valid_q, issue_valid_d;
    logic [WARP_NUM-1:0] ibuf_pop_q, ibuf_pop_d;
    logic [WARP_NUM-1:0] barrier_wait_q, barrier_wait_d;

    logic [WARP_NUM-1:0] slot_mask;
    logic [WARP_NUM-1:0] eligible;
    warp_num_t           pick_last;
    warp_num_t           pick_index;
    logic                pick_found;

    // The warp sitting in the slot is never eligible, so a back-to-back load
    // always moves on to a different warp.
    always_comb begin
        slot_mask = issue_valid_q ? ~warp_onehot(issue_warp_q) : '1;
        eligible  = ibuf_valid & sb_ready & ~barrier_wait_q & slot_mask;
        // In HOLD the search only matters on a handshake, where last_warp is
        // about to become the issued warp; search from there directly.
        pick_last = (state_q == HOLD) ? issue_warp_q : last_warp_q;
    end

    gelato_rr_picker #(
        .N     (WARP_NUM),
        .IDX_W (WARP_W)
    ) u_picker (
        .mask  (eligible),
        .last  (pick_last),
        .found (pick_found),
        .index (pick_index)
    );

    always_comb begin
        state_d        = state_q;
        last_warp_d    = last_warp_q;
        issue_warp_d   = issue_warp_q;
        issue_inst_d   = issue_inst_q;
        issue_valid_d  = issue_valid_q;
        ibuf_pop_d     = '0;
        barrier_wait_d = barrier_wait_q;

        if (rdy) begin
            case (state_q)
                SELECT: begin
                    if (pick_found) begin
                        issue_valid_d = 1'b1;
                        issue_warp_d  = pick_index;
                        issue_inst_d  = ibuf_inst[pick_index];
                        ibuf_pop_d    = warp_onehot(pick_index);
                        state_d       = HOLD;
                    end else begin
                        issue_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (issue_ready) begin
                        last_warp_d = issue_warp_q;
                        if (pick_found) begin
                            issue_warp_d = pick_index;
                            issue_inst_d = ibuf_inst[pick_index];
                            ibuf_pop_d   = warp_onehot(pick_index);
                        end else begin
                            issue_valid_d = 1'b0;
                            state_d       = SELECT;
                        end
                    end
                end
                default: state_d = SELECT;
            endcase

            // Release wins over older waits, but a same-cycle set survives.
            if (barrier_release) begin
                barrier_wait_d = '0;
            end
            if (barrier_set) begin
                barrier_wait_d[barrier_warp_num] = 1'b1;
            end
        end else begin
            // Keep a pending pop pulse so it still appears once rdy returns.
            ibuf_pop_d = ibuf_pop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SELECT;
            last_warp_q    <= warp_num_t'(WARP_NUM - 1);
            issue_warp_q   <= '0;
            issue_inst_q   <= '0;
            issue_valid_q  <= 1'b0;
            ibuf_pop_q     <= '0;
            barrier_wait_q <= '0;
        end else begin
            state_q        <= state_d;
            last_warp_q    <= last_warp_d;
            issue_warp_q   <= issue_warp_d;
            issue_inst_q   <= issue_inst_d;
            issue_valid_q  <= issue_valid_d;
            ibuf_pop_q     <= ibuf_pop_d;
            barrier_wait_q <= barrier_wait_d;
        end
    end

    assign ibuf_pop       = ibuf_pop_q & {WARP_NUM{rdy}};
    assign issue_valid    = issue_valid_q;
    assign issue_warp_num = issue_warp_q;
    assign issue_inst     = issue_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_gelato_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gelato_issue_scheduler
//  Description : Self-checking bench for gelato_issue_scheduler. A behavioural
//                model tracks the issue slot, last granted warp and barrier
//                waits; directed scenarios plus a randomized run are compared
//                against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gelato_issue_scheduler;
    import gelato_types::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rdy;
    logic [WARP_NUM-1:0] ibuf_valid;
    inst_t               ibuf_inst [WARP_NUM];
    logic [WARP_NUM-1:0] sb_ready;
    logic [WARP_NUM-1:0] ibuf_pop;
    logic                issue_valid;
    logic                issue_ready;
    warp_num_t           issue_warp_num;
    inst_t               issue_inst;
    logic                barrier_set;
    warp_num_t           barrier_warp_num;
    logic                barrier_release;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_valid;
    int          m_warp;
    logic [31:0] m_inst;
    int          m_pop;     // -1: no pop pending
    int          m_last;
    bit [31:0]   m_bw;

    gelato_issue_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy              (rdy),
        .ibuf_valid       (ibuf_valid),
        .ibuf_inst        (ibuf_inst),
        .sb_ready         (sb_ready),
        .ibuf_pop         (ibuf_pop),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_warp_num   (issue_warp_num),
        .issue_inst       (issue_inst),
        .barrier_set      (barrier_set),
        .barrier_warp_num (barrier_warp_num),
        .barrier_release  (barrier_release)
    );

    always #5 clk = ~clk;

    function automatic bit elig(int j);
        return ibuf_valid[j] && sb_ready[j] && !m_bw[j] && !(m_valid && m_warp == j);
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int start;
        int pick;
        bit handshake;
        if (!rst_n) begin
            m_valid = 0; m_warp = 0; m_inst = '0; m_pop = -1; m_last = 31; m_bw = '0;
        end else if (rdy) begin
            handshake = m_valid && issue_ready;
            m_pop = -1;
            if (!m_valid || handshake) begin
                start = handshake ? m_warp : m_last;
                pick = -1;
                for (int k = 1; k <= 32; k++) begin
                    if (pick < 0 && elig((start + k) % 32)) pick = (start + k) % 32;
                end
                if (handshake) m_last = m_warp;
                if (pick >= 0) begin
                    m_valid = 1; m_warp = pick; m_inst = ibuf_inst[pick]; m_pop = pick;
                end else begin
                    m_valid = 0;
                end
            end
            if (barrier_release) m_bw = '0;
            if (barrier_set) m_bw[barrier_warp_num] = 1'b1;
        end
    endtask

    function automatic logic [69:0] exp_bus();
        logic [31:0] pop;
        pop = (m_pop >= 0 && rdy) ? (32'd1 << m_pop) : 32'd0;
        return {m_valid, 5'(m_warp), m_inst, pop};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy = 1; ibuf_valid = '0; sb_ready = '1; issue_ready = 0;
        barrier_set = 0; barrier_warp_num = '0; barrier_release = 0;
        for (int i = 0; i < WARP_NUM; i++) ibuf_inst[i] = 32'hC0DE_0000 | 32'(i);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0; rdy = 0; ibuf_valid = '1; issue_ready = 1; barrier_set = 1;
        tick();
        tick();
        vectors++;
        if ({issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset: got %h expected 0", {issue_valid, issue_warp_num, issue_inst, ibuf_pop});
        end
        rst_n = 1;
    endtask

    task automatic test_first_issue();
        do_reset();
        ibuf_valid = 32'h0000_0009;
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_warp_num !== 5'd0 || ibuf_pop !== 32'h1 ||
            {issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
            miscompares++;
            $display("FAIL first_issue: got v=%b w=%0d pop=%h expected v=1 w=0 pop=1", issue_valid, issue_warp_num, ibuf_pop);
        end
        issue_ready = 1;
        tick();
        vectors++;
        if (issue_warp_num !== 5'd3 || ibuf_pop !== 32'h8 ||
            {issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
            miscompares++;
            $display("FAIL second_issue: got w=%0d pop=%h expected w=3 pop=8", issue_warp_num, ibuf_pop);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ibuf_valid = '1; issue_ready = 1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            vectors++;
            if (issue_valid !== 1'b1 || issue_warp_num !== 5'(k % 32) || ibuf_pop !== (32'd1 << (k % 32)) ||
                {issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got v=%b w=%0d pop=%h expected w=%0d", k, issue_valid, issue_warp_num, ibuf_pop, k % 32);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ibuf_valid = 32'h0000_0020;
        tick();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (issue_valid !== 1'b1 || issue_warp_num !== 5'd5 || issue_inst !== 32'hC0DE_0005 ||
                ibuf_pop !== ((k == 0) ? 32'h20 : 32'h0)) begin
                miscompares++;
                $display("FAIL stall[%0d]: got w=%0d inst=%h pop=%h expected w=5 inst=c0de0005", k, issue_warp_num, issue_inst, ibuf_pop);
            end
            ibuf_inst[5] = $urandom;
            tick();
        end
    endtask

    task automatic test_barrier();
        do_reset();
        barrier_set = 1; barrier_warp_num = 5'd2; issue_ready = 1;
        tick();
        barrier_set = 0; ibuf_valid = 32'h0000_0014;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if ((issue_valid && issue_warp_num === 5'd2) ||
                {issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
                miscompares++;
                $display("FAIL barrier_block[%0d]: got v=%b w=%0d expected %h", k, issue_valid, issue_warp_num, exp_bus());
            end
        end
        barrier_release = 1;
        tick();
        barrier_release = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
                miscompares++;
                $display("FAIL barrier_release[%0d]: got %h expected %h", k, {issue_valid, issue_warp_num, issue_inst, ibuf_pop}, exp_bus());
            end
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        ibuf_valid = 32'h0000_0080;
        tick();
        issue_ready = 1; rdy = 0; ibuf_valid = 32'h0000_0280;
        barrier_set = 1; barrier_warp_num = 5'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== {1'b1, 5'd7, 32'hC0DE_0007, 32'h0}) begin
                miscompares++;
                $display("FAIL rdy_freeze[%0d]: got v=%b w=%0d pop=%h expected v=1 w=7 pop=0", k, issue_valid, issue_warp_num, ibuf_pop);
            end
        end
        rdy = 1; barrier_set = 0;
        tick();
        vectors++;
        if (issue_warp_num !== 5'd9 || {issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus()) begin
            miscompares++;
            $display("FAIL rdy_resume: got w=%0d pop=%h expected w=9", issue_warp_num, ibuf_pop);
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        ibuf_valid = 32'h0000_0010;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; ibuf_valid = '0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (issue_valid !== 1'b0 || ibuf_pop !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got v=%b pop=%h expected v=0 pop=0", k, issue_valid, ibuf_pop);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            ibuf_valid = (n % 50 < 25) ? ($urandom & $urandom) : $urandom;
            sb_ready = $urandom | $urandom;
            issue_ready = ($urandom_range(0, 2) != 0);
            barrier_set = ($urandom_range(0, 4) == 0);
            barrier_warp_num = 5'($urandom);
            barrier_release = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < WARP_NUM; i++) ibuf_inst[i] = $urandom;
            tick();
            vectors++;
            if ({issue_valid, issue_warp_num, issue_inst, ibuf_pop} !== exp_bus() || $countones(ibuf_pop) > 1) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", n, {issue_valid, issue_warp_num, issue_inst, ibuf_pop}, exp_bus());
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        m_valid = 0; m_warp = 0; m_inst = '0; m_pop = -1; m_last = 31; m_bw = '0;
        test_reset();
        test_first_issue();
        test_back_to_back();
        test_stall();
        test_barrier();
        test_rdy_freeze();
        test_reset_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gelato_issue_scheduler.md
GELATO_ISSUE_SCHEDULER -- requirements
Module: gelato_issue_scheduler

Interface
REQ-001 SHALL use `WARP_NUM` (package constant, default 32), number of warps arbitrated.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port rdy, input, 1, global enable; when low, all state and outputs frozen.
REQ-005 SHALL have port ibuf_valid, input, [`WARP_NUM], instruction buffer holds a decoded instruction for warp i.
REQ-006 SHALL have port ibuf_inst, input, inst_t[`WARP_NUM], head instruction per warp.
REQ-007 SHALL have port sb_ready, input, [`WARP_NUM], scoreboard reports no hazard for warp i head instruction.
REQ-008 SHALL have port ibuf_pop, output, [`WARP_NUM], one-hot single-cycle pop of warp head.
REQ-009 SHALL have port issue_valid, output, 1, issue slot holds an instruction.
REQ-010 SHALL have port issue_ready, input, 1, execute stage accepts the slot.
REQ-011 SHALL have port issue_warp_num, output, warp_num_t, warp of issued instruction.
REQ-012 SHALL have port issue_inst, output, inst_t, issued instruction.
REQ-013 SHALL have port barrier_set, input, 1, warp barrier_warp_num reached a barrier.
REQ-014 SHALL have port barrier_warp_num, input, warp_num_t, warp for barrier_set.
REQ-015 SHALL have port barrier_release, input, 1, clear all barrier waits.

Function
REQ-016 Eligible(i) SHALL be ibuf_valid[i] & sb_ready[i] & !barrier_wait[i] & !(issue_valid & issue_warp_num==i).
REQ-017 Selection SHALL be round-robin: first eligible warp searching last_warp+1, last_warp+2, ... modulo `WARP_NUM`, wrapping past `WARP_NUM`-1 to 0; last_warp itself is checked last.
REQ-018 FSM SHALL have states SELECT and HOLD.
REQ-019 SELECT: if any warp eligible, load slot (issue_valid<=1, warp, inst), assert ibuf_pop[w] for exactly that next cycle, go HOLD; else stay, issue_valid=0.
REQ-020 HOLD: slot contents SHALL remain stable while issue_ready low.
REQ-021 HOLD with issue_ready=1: last_warp<=issue_warp_num; if another warp eligible (per REQ-016, issued warp excluded), load it back-to-back and stay HOLD; else issue_valid<=0, go SELECT.
REQ-022 Latency: eligibility at cycle N SHALL produce issue_valid at N+1; peak throughput one issue per cycle.
REQ-023 ibuf_pop SHALL be all-zero except the single cycle following a slot load; never more than one bit set.
REQ-024 barrier_set SHALL set barrier_wait[barrier_warp_num] next cycle; barrier_release SHALL clear all bits; both same cycle: release clears all others, barrier_warp_num remains set.
REQ-025 barrier_set on the warp currently in the slot SHALL NOT cancel the held instruction.
REQ-026 rdy low SHALL ignore issue_ready, barrier inputs and selection; ibuf_pop SHALL be 0 while rdy low.

Reset
REQ-027 On rst_n low at posedge: state=SELECT, last_warp=`WARP_NUM`-1 (first search starts at warp 0), issue_valid=0, issue_warp_num=0, issue_inst=0, ibuf_pop=0, barrier_wait all 0.
REQ-028 Reset mid-HOLD SHALL drop the held instruction with no pop or issue afterwards.
REQ-029 Reset SHALL take priority over rdy.

Structure
REQ-030 warp_num_t, inst_t, `WARP_NUM SHALL come from gelato_types package; FSM state enum local.
REQ-031 Round-robin search SHALL be sub-module gelato_rr_picker (inputs mask, last index; outputs found, index).

Verification
REQ-032 Reset, warps 0 and 3 eligible -> issue warp 0 at cycle 1, ibuf_pop=0001 at cycle 1; after handshake, warp 3 next.
REQ-033 All 32 eligible, issue_ready held 1 -> warps issued 0,1,...,31,0 consecutively, one per cycle.
REQ-034 Warp 5 loaded, issue_ready low 4 cycles -> issue_warp_num=5 and issue_inst stable, ibuf_pop pulses once.
REQ-035 barrier_set warp 2, warps 2,4 eligible -> only 4 issues; barrier_release -> warp 2 issues next.
REQ-036 rdy low 3 cycles during HOLD with issue_ready=1 -> no state change; handshake completes on first rdy-high cycle.
REQ-037 rst_n low during HOLD -> issue_valid=0 next cycle, no subsequent pop of held warp.
